seg_text_scroller: RTL
======================

Name: seg_text_scroller

Overview:
- Character-sequencing stage directly upstream of the 7-segment glyph decoder.
- Buffers a short message of 6-bit character codes (0-15 hex digits, 16-41 letters; any other value decodes to dash).
- Presents one code at a time on char_code, holding each for a programmable number of clk_2 cycles, then a gap, then wraps or stops.
- char_code drives the decoder's 6-bit code input directly; the decoder remains purely combinational.

Parameters:
- MAX_LEN, 16: message buffer depth in characters (power of two, >=2).
- DIV, 2: clk_2 cycles each character is held (>=1).
- GAP_TICKS, 2: clk_2 cycles of GAP_CODE after the last character (0 = no gap).
- GAP_CODE, 42: code shown in idle and in gap; 42 decodes to dash.
- REPEAT, 1: 1 = wrap to first character after the gap; 0 = return to IDLE.

Ports:
- clk_2, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- wr_valid, input, 1: append wr_code to the buffer.
- wr_code, input, 6: character code to append.
- wr_ready, output, 1: buffer accepts a write this cycle.
- clear, input, 1: empty the buffer (IDLE only).
- start, input, 1: begin scrolling.
- stop, input, 1: abort scrolling and return to IDLE.
- char_code, output, 6: code to the glyph decoder.
- char_valid, output, 1: high while a buffered character is shown.
- pos, output, $clog2(MAX_LEN): index of the character shown.
- len, output, $clog2(MAX_LEN)+1: number of buffered characters.
- busy, output, 1: state is SHOW or GAP.

Behaviour:
- Reset (async, any state, mid-scroll included):
  - state=IDLE, len=0, pos=0, tick=0.
  - char_code=GAP_CODE, char_valid=0, busy=0, wr_ready=1.
  - Buffer contents are don't-care.
- States: IDLE, SHOW, GAP. busy=(state!=IDLE). char_valid=(state==SHOW).
- char_code = buf[pos] in SHOW, GAP_CODE otherwise. Combinational from registered pos/state; zero latency from state.
- wr_ready = (state==IDLE) && (len<MAX_LEN).
- Write: wr_valid && wr_ready at edge stores buf[len]=wr_code; len+1 is visible next cycle. Writes when not ready are dropped silently.
- clear in IDLE: len=0 next cycle.
  - clear and wr_valid in the same cycle: clear wins, write dropped.
  - clear outside IDLE: ignored.
- IDLE->SHOW on start when effective length >0:
  - Effective length = len plus 1 if a write is accepted in the same cycle. The write is stored and scrolling starts with the new length.
  - Sets pos=0, tick=0.
  - start with effective length 0: ignored.
  - start and clear in the same cycle: clear wins, start ignored.
- SHOW:
  - tick counts 0..DIV-1.
  - At tick==DIV-1: tick=0.
    - If pos<len-1: pos+1.
    - Else if GAP_TICKS>0: go to GAP.
    - Else if REPEAT=1: pos=0, stay in SHOW.
    - Else: go to IDLE.
  - Each character is visible exactly DIV cycles.
- GAP:
  - tick counts 0..GAP_TICKS-1, pos holds len-1.
  - At the end of the gap: REPEAT=1 -> SHOW with pos=0, tick=0. REPEAT=0 -> IDLE with pos=0.
- stop in SHOW or GAP: IDLE next cycle, pos=0, tick=0, buffer and len retained. stop has priority over any same-cycle transition. stop in IDLE: ignored.
- start while busy: ignored.
- len==1 case: the single character is shown DIV cycles, then the gap, then it repeats.
- len==MAX_LEN: pos wraps via the compare against len-1, never by counter overflow.
- Widths: counter width is $clog2(max(DIV,GAP_TICKS,2)); all compares are unsigned.

Test Plan:
- Reset mid-scroll: assert reset during SHOW with pos=2 -> same cycle char_code=42, char_valid=0, len=0, busy=0, wr_ready=1.
- Load and scroll (DIV=2, GAP_TICKS=2, REPEAT=1):
  - Stimulus: write 24,21,29,31 then start.
  - Required char_code per cycle: 24,24,21,21,29,29,31,31,42,42,24,24...
  - char_valid low only during the two 42 cycles; pos sequence 0,0,1,1,2,2,3,3,3,3,0.
- Full buffer: write 17 codes with MAX_LEN=16 -> len=16 and wr_ready=0 after the 16th write. 17th write dropped; last scrolled code equals the 16th written.
- Simultaneous events (all in IDLE):
  - clear+wr_valid -> len=0.
  - start+wr_valid(code 5) with len=0 -> SHOW, char_code=5.
  - start with len=0 -> stays IDLE.
- stop and REPEAT=0:
  - stop during GAP -> IDLE next cycle, char_code=42, len unchanged.
  - With REPEAT=0, message 12 only -> 12,12,42,42, then IDLE with busy=0.
- Writes while busy: wr_valid during SHOW -> wr_ready=0, len unchanged, displayed sequence unaffected.

Source files
------------

// File: rtl/seg_text_scroller_if.sv
// Bus bundle between the message source / scroll controller and the scroller stage.
// The master side writes characters and controls scrolling; the slave side presents glyph codes.
interface seg_text_scroller_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = $clog2(MAX_LEN);

    logic          wr_valid;
    logic [5:0]    wr_code;
    logic          wr_ready;
    logic          clear;
    logic          start;
    logic          stop;
    logic [5:0]    char_code;
    logic          char_valid;
    logic [AW-1:0] pos;
    logic [AW:0]   len;
    logic          busy;

    modport master (
        output wr_valid, wr_code, clear, start, stop,
        input  wr_ready, char_code, char_valid, pos, len, busy
    );

    modport slave (
        input  wr_valid, wr_code, clear, start, stop,
        output wr_ready, char_code, char_valid, pos, len, busy
    );
endinterface

// File: rtl/seg_text_scroller.sv
// Buffers a short message of 6-bit character codes and presents them one at a time,
// each held DIV cycles, followed by an optional gap, then wraps or returns to idle.
module seg_text_scroller #(
    parameter int MAX_LEN   = 16,
    parameter int DIV       = 2,
    parameter int GAP_TICKS = 2,
    parameter int GAP_CODE  = 42,
    parameter int REPEAT    = 1
) (
    input  logic                clk_2,
    input  logic                reset,
    seg_text_scroller_if.slave  bus
);
    localparam int AW   = $clog2(MAX_LEN);
    localparam int LW   = AW + 1;
    localparam int CMAX = (DIV > GAP_TICKS) ? ((DIV > 2) ? DIV : 2)
                                            : ((GAP_TICKS > 2) ? GAP_TICKS : 2);
    localparam int CW   = $clog2(CMAX);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [5:0]    GAP_C    = 6'(GAP_CODE);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
    localparam logic [CW-1:0] TICK_ONE = CW'(1);
    localparam logic [CW-1:0] TICK_Z   = CW'(0);
    localparam logic [AW-1:0] POS_ONE  = AW'(1);
    localparam logic [AW-1:0] POS_Z    = AW'(0);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);
    localparam logic [LW-1:0] LEN_Z    = LW'(0);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] len_q,   len_d;
    logic [AW-1:0] pos_q,   pos_d;
    logic [CW-1:0] tick_q,  tick_d;
    logic [5:0]    msg_q [MAX_LEN];

    logic wr_ready_s;
    logic wr_acc_s;
    logic is_last_s;

    // Write acceptance and end-of-message detection
    always_comb begin
        wr_ready_s = (state_q == ST_IDLE) && (len_q < LEN_MAX);
        wr_acc_s   = bus.wr_valid && wr_ready_s && !bus.clear;
        is_last_s  = ({1'b0, pos_q} >= (len_q - LEN_ONE));
    end

    // Next-state logic for the scroll sequencer
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE: begin
                pos_d  = POS_Z;
                tick_d = TICK_Z;
                if (bus.clear) begin
                    len_d   = LEN_Z;
                    state_d = ST_IDLE;
                end else begin
                    if (wr_acc_s) begin
                        len_d = len_q + LEN_ONE;
                    end else begin
                        len_d = len_q;
                    end
                    // Starting uses the length including a same-cycle write
                    if (bus.start && (len_d != LEN_Z)) begin
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SHOW: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    pos_d   = POS_Z;
                    tick_d  = TICK_Z;
                end else if (tick_q == DIV_LAST) begin
                    tick_d = TICK_Z;
                    if (!is_last_s) begin
                        pos_d = pos_q + POS_ONE;
                    end else if (GAP_TICKS > 0) begin
                        state_d = ST_GAP;
                    end else if (REPEAT != 0) begin
                        pos_d = POS_Z;
                    end else begin
                        state_d = ST_IDLE;
                        pos_d   = POS_Z;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            ST_GAP: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    pos_d   = POS_Z;
                    tick_d  = TICK_Z;
                end else if (tick_q == GAP_LAST) begin
                    tick_d = TICK_Z;
                    pos_d  = POS_Z;
                    if (REPEAT != 0) begin
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = POS_Z;
                tick_d  = TICK_Z;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= LEN_Z;
            pos_q   <= POS_Z;
            tick_q  <= TICK_Z;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
        end
    end

    // Message storage; contents need no reset since len gates visibility
    always_ff @(posedge clk_2) begin
        if (wr_acc_s) begin
            msg_q[len_q[AW-1:0]] <= bus.wr_code;
        end
    end

    assign bus.wr_ready   = wr_ready_s;
    assign bus.char_code  = (state_q == ST_SHOW) ? msg_q[pos_q] : GAP_C;
    assign bus.char_valid = (state_q == ST_SHOW);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.pos        = pos_q;
    assign bus.len        = len_q;
endmodule
